// File: rtl/edm_pulse_sequencer.sv
// Discharge pulse sequencer: runs Ton/Toff periods against an external timer
// count, issues spaced timer commands and drives the power-stage gate.
module edm_pulse_sequencer #(
  parameter int WIDTH        = 16,
  parameter int SYNC_TIMEOUT = 15,
  parameter int CMD_GAP      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             hold,
  input  logic [WIDTH-1:0] ton,
  input  logic [WIDTH-1:0] toff,
  input  logic [WIDTH-1:0] timer_value,
  output logic             timer_start,
  output logic             timer_stand,
  output logic             timer_reset,
  output logic             timer_restart,
  output logic             gate_out,
  output logic             period_done,
  output logic             sync_fault,
  output logic [2:0]       state_out
);
  localparam int SW = $clog2(SYNC_TIMEOUT + 1);
  localparam int GW = $clog2(CMD_GAP + 2);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_MIN   = GW'(CMD_GAP);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ON = 3'd1, S_OFF = 3'd2, S_SYNC = 3'd3, S_PAUSE = 3'd4, S_FAULT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_START, CMD_STAND, CMD_RESET, CMD_RESTART
  } cmd_t;

  state_t           state_reg, state_next;
  cmd_t             cmd_req, cmd_cand, pend_reg, pend_next;
  logic [WIDTH-1:0] ton_l_reg;
  logic [WIDTH:0]   period_l_reg, period_in, tv_ext;
  logic [SW-1:0]    sync_cnt_reg, sync_cnt_next;
  logic [GW-1:0]    gap_cnt_reg;
  logic             latch_en, done_set, fault_set, fault_clr, issue;

  // All comparisons are one bit wider so ton=toff=all-ones cannot wrap.
  assign tv_ext    = {1'b0, timer_value};
  assign period_in = {1'b0, ton} + ((toff == '0) ? ONE_EXT : {1'b0, toff});

  always_comb begin
    state_next    = state_reg;
    cmd_req       = CMD_NONE;
    latch_en      = 1'b0;
    done_set      = 1'b0;
    fault_set     = 1'b0;
    fault_clr     = 1'b0;
    sync_cnt_next = sync_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (enable && !hold) begin
          latch_en   = 1'b1;
          cmd_req    = CMD_START;
          state_next = (ton == '0) ? S_OFF : S_ON;
        end
      end
      S_FAULT: begin
        if (!enable) begin
          state_next = S_IDLE;
          fault_clr  = 1'b1;
        end
      end
      default: begin
        if (!enable) begin
          cmd_req    = CMD_RESET;
          state_next = S_IDLE;
        end else if (hold) begin
          if (state_reg != S_PAUSE) begin
            cmd_req    = CMD_STAND;
            state_next = S_PAUSE;
          end
        end else begin
          case (state_reg)
            S_ON: begin
              if (tv_ext >= {1'b0, ton_l_reg}) state_next = S_OFF;
            end
            S_OFF: begin
              if (tv_ext >= period_l_reg) begin
                cmd_req       = CMD_RESTART;
                done_set      = 1'b1;
                sync_cnt_next = '0;
                state_next    = S_SYNC;
              end
            end
            S_SYNC: begin
              // A count back at 0/1 means the timer has taken the restart.
              if (tv_ext < period_l_reg && tv_ext <= ONE_EXT) begin
                latch_en   = 1'b1;
                state_next = (ton == '0) ? S_OFF : S_ON;
              end else if (sync_cnt_reg == SYNC_LAST) begin
                fault_set  = 1'b1;
                cmd_req    = CMD_RESET;
                state_next = S_FAULT;
              end else begin
                sync_cnt_next = sync_cnt_reg + 1'b1;
              end
            end
            S_PAUSE: begin
              cmd_req    = CMD_START;
              state_next = S_OFF;
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // One deferred command slot; a newer request replaces an older deferred one.
  assign cmd_cand = (pend_reg != CMD_NONE) ? pend_reg : cmd_req;
  assign issue    = (cmd_cand != CMD_NONE) && (gap_cnt_reg >= GAP_MIN);

  always_comb begin
    if (issue) begin
      pend_next = (pend_reg != CMD_NONE) ? cmd_req : CMD_NONE;
    end else if (cmd_req != CMD_NONE) begin
      pend_next = cmd_req;
    end else begin
      pend_next = pend_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      pend_reg      <= CMD_NONE;
      gap_cnt_reg   <= GAP_MIN;
      sync_cnt_reg  <= '0;
      ton_l_reg     <= '0;
      period_l_reg  <= '0;
      timer_start   <= 1'b0;
      timer_stand   <= 1'b0;
      timer_reset   <= 1'b0;
      timer_restart <= 1'b0;
      gate_out      <= 1'b0;
      period_done   <= 1'b0;
      sync_fault    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_reg     <= pend_next;
      sync_cnt_reg <= sync_cnt_next;
      if (latch_en) begin
        ton_l_reg    <= ton;
        period_l_reg <= period_in;
      end
      gate_out    <= (state_next == S_ON);
      period_done <= done_set;
      if (fault_set) begin
        sync_fault <= 1'b1;
      end else if (fault_clr) begin
        sync_fault <= 1'b0;
      end
      timer_start   <= issue && (cmd_cand == CMD_START);
      timer_stand   <= issue && (cmd_cand == CMD_STAND);
      timer_reset   <= issue && (cmd_cand == CMD_RESET);
      timer_restart <= issue && (cmd_cand == CMD_RESTART);
      if (issue) begin
        gap_cnt_reg <= '0;
      end else if (gap_cnt_reg < GAP_MIN) begin
        gap_cnt_reg <= gap_cnt_reg + 1'b1;
      end
    end
  end

  assign state_out = state_reg;

endmodule
